// File: rtl/thermal_head_driver.sv
// thermal_head_driver: serialises one AXI-stream dot line onto the head mechanism, then pulses latch and strobe.
// Ports:
//   clk, reset (async, active-low)
//   s_axi_valid/s_axi_ready/s_axi_data : one dot line per handshake, bit HEAD_WIDTH-1 shifted first
//   mech_clk, mech_data                : serial shift clock and data to the head
//   mech_latch                         : active-low latch pulse after the line is shifted
//   mech_dst                           : active-high strobe (burn) pulse after the latch
//   busy                               : high while a line is in progress
module thermal_head_driver #(
    parameter int HEAD_WIDTH   = 384,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 4,
    parameter int DST_CYCLES   = 64,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axi_valid,
    output logic                  s_axi_ready,
    input  logic [HEAD_WIDTH-1:0] s_axi_data,
    output logic                  mech_clk,
    output logic                  mech_data,
    output logic                  mech_latch,
    output logic                  mech_dst,
    output logic                  busy
);
    localparam int MAX_A = CLK_DIV > LATCH_CYCLES ? CLK_DIV : LATCH_CYCLES;
    localparam int MAX_B = DST_CYCLES > GAP_CYCLES ? DST_CYCLES : GAP_CYCLES;
    localparam int MAX_N = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int BW = $clog2(HEAD_WIDTH + 1);
    localparam int CW = $clog2(MAX_N + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(HEAD_WIDTH - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LAT_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] DST_LAST = CW'(DST_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    if (CLK_DIV < 1 || LATCH_CYCLES < 1 || DST_CYCLES < 1) begin : g_bad_param
        $error("thermal_head_driver: CLK_DIV, LATCH_CYCLES and DST_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, SHIFT, LATCH, STROBE, GAP} state_t;

    state_t                state_q, state_d;
    logic [HEAD_WIDTH-1:0] shift_q, shift_d, shifted;
    logic [BW-1:0]         bit_q, bit_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  mech_clk_q, mech_clk_d;
    logic                  mech_data_q, mech_data_d;
    logic                  mech_latch_q, mech_latch_d;
    logic                  mech_dst_q, mech_dst_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    // Every output is computed from the next state and registered, so nothing
    // on s_axi_* reaches an output combinationally.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        mech_clk_d   = mech_clk_q;
        mech_data_d  = mech_data_q;
        mech_latch_d = mech_latch_q;
        mech_dst_d   = mech_dst_q;
        ready_d      = ready_q;
        shifted      = shift_q << 1;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (s_axi_valid && ready_q) begin
                    state_d     = SHIFT;
                    shift_d     = s_axi_data;
                    bit_d       = '0;
                    cnt_d       = '0;
                    mech_data_d = s_axi_data[HEAD_WIDTH-1];
                    ready_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d      = '0;
                    mech_clk_d = !mech_clk_q;
                    // Data only moves at the end of a high phase, i.e. as mech_clk falls.
                    if (mech_clk_q) begin
                        if (bit_q == BIT_LAST) begin
                            state_d      = LATCH;
                            mech_data_d  = 1'b0;
                            mech_latch_d = 1'b0;
                        end else begin
                            bit_d       = bit_q + 1'b1;
                            shift_d     = shifted;
                            mech_data_d = shifted[HEAD_WIDTH-1];
                        end
                    end
                end
            end
            LATCH: begin
                if (cnt_q != LAT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d        = '0;
                    mech_latch_d = 1'b1;
                    mech_dst_d   = 1'b1;
                    state_d      = STROBE;
                end
            end
            STROBE: begin
                if (cnt_q != DST_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d      = '0;
                    mech_dst_d = 1'b0;
                    state_d    = GAP_CYCLES == 0 ? IDLE : GAP;
                    ready_d    = GAP_CYCLES == 0;
                end
            end
            GAP: begin
                if (cnt_q != GAP_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_q        <= '0;
            cnt_q        <= '0;
            mech_clk_q   <= 1'b0;
            mech_data_q  <= 1'b0;
            mech_latch_q <= 1'b1;
            mech_dst_q   <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            mech_clk_q   <= mech_clk_d;
            mech_data_q  <= mech_data_d;
            mech_latch_q <= mech_latch_d;
            mech_dst_q   <= mech_dst_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign s_axi_ready = ready_q;
    assign mech_clk    = mech_clk_q;
    assign mech_data   = mech_data_q;
    assign mech_latch  = mech_latch_q;
    assign mech_dst    = mech_dst_q;
    assign busy        = busy_q;
endmodule

// File: doc/thermal_head_driver.md
Name: thermal_head_driver

Overview:
AXI-stream-to-print-mechanism transmitter and the counterpart of the thermal head capture path. It accepts one dot line per handshake and serialises it onto mech_clk/mech_data. It then issues a latch pulse and a strobe (DST) pulse. It drives the analyser's mechanism inputs for self-test and loopback, generating waveforms the head capture logic must reconstruct bit-exactly.

Parameters:
HEAD_WIDTH, 384, dots per line / bits shifted per line.
CLK_DIV, 4, clk cycles per mech_clk phase (low and high each); >=1.
LATCH_CYCLES, 4, clk cycles mech_latch is held low; >=1.
DST_CYCLES, 64, clk cycles mech_dst is held high; >=1.
GAP_CYCLES, 2, idle clk cycles after strobe before the next line is accepted; >=0.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
s_axi_valid  input  1  dot line available.
s_axi_ready  output  1  driver can accept a line.
s_axi_data  input  HEAD_WIDTH  dot line; bit HEAD_WIDTH-1 is shifted first.
mech_clk  output  1  serial shift clock to head.
mech_data  output  1  serial dot data.
mech_latch  output  1  latch pulse, active-low, idle high.
mech_dst  output  1  strobe/burn pulse, active-high, idle low.
busy  output  1  high whenever a line is in progress (state != IDLE).

Behaviour:
- Reset state: reset=0 forces the following immediately (async), regardless of state: IDLE, s_axi_ready=0, mech_clk=0, mech_data=0, mech_latch=1, mech_dst=0, busy=0. The shift register and counters are cleared.
- First clk edge after reset release: s_axi_ready=1.
- Reset mid-line aborts the line with no partial latch/strobe. Mech outputs go to idle levels immediately.
- All outputs are registered; no combinational path from s_axi_* to any output.
- FSM states: IDLE, SHIFT, LATCH, STROBE, GAP.
- IDLE: s_axi_ready=1.
  - On an edge (T0) where s_axi_valid&&s_axi_ready: capture s_axi_data into the shift register, bit counter=0, go to SHIFT.
  - s_axi_ready=0 from T0+1.
  - s_axi_data is ignored outside the handshake cycle.
- SHIFT: per bit, mech_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mech_data presents the current bit from the start of the low phase; it changes only while mech_clk is low.
  - It is stable for the full CLK_DIV cycles before and after each rising edge.
  - Bit order is MSB first: bit HEAD_WIDTH-1 appears at T0+1. The first rising edge is at T0+1+CLK_DIV.
  - After the high phase of bit index HEAD_WIDTH-1, at T0+1+2*CLK_DIV*HEAD_WIDTH: mech_clk=0, mech_data=0, go to LATCH.
  - Exactly HEAD_WIDTH rising edges per line.
- LATCH: mech_latch=0 for exactly LATCH_CYCLES cycles, then mech_latch=1 and go to STROBE.
- STROBE: mech_dst=1 for exactly DST_CYCLES cycles, then mech_dst=0.
  - Go to GAP, or directly to IDLE if GAP_CYCLES=0.
  - Latch and strobe never overlap; mech_clk stays low in LATCH/STROBE/GAP.
- GAP: all mech outputs idle for GAP_CYCLES, then IDLE.
- Line period: s_axi_ready returns high at T0+1+2*CLK_DIV*HEAD_WIDTH+LATCH_CYCLES+DST_CYCLES+GAP_CYCLES.
  - A valid held high is accepted on that same cycle's edge, giving back-to-back lines.
- s_axi_valid may drop without handshake; no state change.
- Counter widths: bit counter $clog2(HEAD_WIDTH+1); phase/pulse counter $clog2 of max(CLK_DIV, LATCH_CYCLES, DST_CYCLES, GAP_CYCLES)+1.
- Elaboration error if CLK_DIV, LATCH_CYCLES or DST_CYCLES is 0.

Test Plan:
All scenarios use HEAD_WIDTH=8, CLK_DIV=2, LATCH_CYCLES=3, DST_CYCLES=5, GAP_CYCLES=2.
- Single line: send 0xA5 at T0 -> mech_data sampled at 8 rising edges = 1,0,1,0,0,1,0,1; first rise at T0+3. mech_latch low T0+33..T0+35; mech_dst high T0+36..T0+40; s_axi_ready=1 at T0+43; busy high T0+1..T0+42.
- Back-to-back: valid held with 0xFF then 0x01 -> second handshake at T0+43; second line's first rising edge at T0+46 shows 0,...,0,1; exactly 16 rising edges total.
- Source stability: change s_axi_data to 0x00 at T0+1 with valid low -> the shifted line is still 0xA5; no second handshake.
- Reset mid-SHIFT: assert reset at T0+10 -> mech_clk=0, mech_data=0, mech_latch=1, mech_dst=0 within the same cycle; no latch/dst pulse. After release, s_axi_ready=1 on the first edge; a new 0x3C then shifts correctly.
- Loopback: connect outputs to the head capture block (HEAD_WIDTH=8); send 0xC3 -> the capture side emits exactly one AXI word 0xC3 per line for 4 consecutive lines.
- Waveform checker: over 20 random lines, mech_data never changes while mech_clk=1; mech_latch and mech_dst are never simultaneously active.
